// File: rtl/iob_timer_alarm_sched.sv
// Multi-channel 64-bit alarm scheduler for the IOB timer: one shared >= comparator
// scans the channels round-robin and raises pending bits, with optional periodic reload.
module iob_timer_alarm_sched #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  input  logic [63:0]           timer_value,
  output logic                  irq
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CH_W   = ADDR_W - 2;

  logic [31:0]       cmp_lo_q [N_CH];
  logic [31:0]       cmp_hi_q [N_CH];
  logic [31:0]       period_q [N_CH];
  logic [31:0]       cmp_lo_d [N_CH];
  logic [31:0]       cmp_hi_d [N_CH];
  logic [31:0]       period_d [N_CH];
  logic [N_CH-1:0]   en_q, en_d, pend_q, pend_d, mask_q, mask_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              irq_d;

  logic [DATA_W-1:0] bmask;
  logic [31:0]       wr32, m32, rd32;
  logic              wr_en, ch_addr, pend_addr, mask_addr;
  logic [CH_W-1:0]   ch_idx;
  logic [PTR_W-1:0]  ch_sel;
  logic [1:0]        reg_k;
  logic [63:0]       cur_cmp, next_cmp;
  logic              hit, hit_blocked, hit_ok;

  function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] wr,
                                          input logic [31:0] m);
    return (old & ~m) | (wr & m);
  endfunction

  // Bus decode and byte-lane mask
  always_comb begin
    bmask = '0;
    for (int b = 0; b < STRB_W; b++) bmask[8*b +: 8] = {8{wstrb[b]}};
    wr32      = 32'(wdata);
    m32       = 32'(bmask);
    wr_en     = valid && (|wstrb);
    ch_idx    = address[ADDR_W-1:2];
    ch_sel    = PTR_W'(ch_idx);
    reg_k     = address[1:0];
    ch_addr   = (ch_idx < CH_W'(N_CH));
    pend_addr = (address == ADDR_W'(16));
    mask_addr = (address == ADDR_W'(17));
  end

  // Shared comparator; a CPU write to the scanned channel's CMP/CTRL discards its hit
  assign cur_cmp     = {cmp_hi_q[ptr_q], cmp_lo_q[ptr_q]};
  assign next_cmp    = cur_cmp + {32'd0, period_q[ptr_q]};
  assign hit         = en_q[ptr_q] && (timer_value >= cur_cmp);
  assign hit_blocked = wr_en && ch_addr && (ch_sel == ptr_q) && (reg_k != 2'd2);
  assign hit_ok      = hit && !hit_blocked;

  // Next-state: CPU writes first, then the hit (which never collides with a CMP/CTRL write)
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cmp_lo_d[i] = cmp_lo_q[i];
      cmp_hi_d[i] = cmp_hi_q[i];
      period_d[i] = period_q[i];
    end
    en_d   = en_q;
    pend_d = pend_q;
    mask_d = mask_q;
    ptr_d  = (ptr_q == PTR_W'(N_CH - 1)) ? '0 : ptr_q + PTR_W'(1);

    if (wr_en) begin
      if (ch_addr) begin
        case (reg_k)
          2'd0:    cmp_lo_d[ch_sel] = merge32(cmp_lo_q[ch_sel], wr32, m32);
          2'd1:    cmp_hi_d[ch_sel] = merge32(cmp_hi_q[ch_sel], wr32, m32);
          2'd2:    period_d[ch_sel] = merge32(period_q[ch_sel], wr32, m32);
          default: en_d[ch_sel]     = m32[0] ? wr32[0] : en_q[ch_sel];
        endcase
      end else if (pend_addr) begin
        pend_d = pend_q & ~N_CH'(wr32 & m32);
      end else if (mask_addr) begin
        mask_d = N_CH'(merge32(32'(mask_q), wr32, m32));
      end
    end

    if (hit_ok) begin
      pend_d[ptr_q] = 1'b1;
      if (period_q[ptr_q] != 32'd0) begin
        cmp_lo_d[ptr_q] = next_cmp[31:0];
        cmp_hi_d[ptr_q] = next_cmp[63:32];
      end else begin
        en_d[ptr_q] = 1'b0;
      end
    end

    irq_d = |(pend_d & mask_d);
  end

  // Read mux
  always_comb begin
    rd32 = '0;
    if (ch_addr) begin
      case (reg_k)
        2'd0:    rd32 = cmp_lo_q[ch_sel];
        2'd1:    rd32 = cmp_hi_q[ch_sel];
        2'd2:    rd32 = period_q[ch_sel];
        default: rd32 = {31'd0, en_q[ch_sel]};
      endcase
    end else if (pend_addr) begin
      rd32 = 32'(pend_q);
    end else if (mask_addr) begin
      rd32 = 32'(mask_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cmp_lo_q[i] <= '0;
        cmp_hi_q[i] <= '0;
        period_q[i] <= '0;
      end
      en_q   <= '0;
      pend_q <= '0;
      mask_q <= '0;
      ptr_q  <= '0;
      irq    <= 1'b0;
      ready  <= 1'b0;
      rdata  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cmp_lo_q[i] <= cmp_lo_d[i];
        cmp_hi_q[i] <= cmp_hi_d[i];
        period_q[i] <= period_d[i];
      end
      en_q   <= en_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      ptr_q  <= ptr_d;
      irq    <= irq_d;
      ready  <= valid;
      rdata  <= valid ? DATA_W'(rd32) : '0;
    end
  end

endmodule

// File: tb/tb_iob_timer_alarm_sched.sv
// Directed bench for iob_timer_alarm_sched: bus map, one-shot, periodic, catch-up,
// 64-bit wrap, write/hit collisions and asynchronous reset.
module tb_iob_timer_alarm_sched;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic [63:0]       timer_value;
  logic              irq;

  int checks   = 0;
  int failures = 0;
  int cyc;

  always #5 clk = ~clk;

  iob_timer_alarm_sched #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .timer_value(timer_value), .irq(irq)
  );

  // Edges since reset release; the scan pointer at the next edge is cyc % N_CH
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(negedge clk);
    valid = 1'b1; address = ADDR_W'(a); wdata = d; wstrb = s;
    @(negedge clk);
    valid = 1'b0; wstrb = 4'h0;
    check("wr_ready", 64'(ready), 64'd1);
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    valid = 1'b1; address = ADDR_W'(a); wstrb = 4'h0;
    @(negedge clk);
    valid = 1'b0;
    check({tag, "_ready"}, 64'(ready), 64'd1);
    check(tag, 64'(rdata), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic align_ch0();
    int guard = 0;
    while ((cyc % N_CH) != 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; valid = 1'b0; address = '0; wdata = '0; wstrb = '0; timer_value = '0;
    idle(2);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    rst_n = 1'b1;

    // Bus map
    wr(17, 32'hF);
    rd(17, 32'hF, "mask_rd");
    idle(1);
    check("idle_ready", 64'(ready), 64'd0);
    check("idle_rdata", 64'(rdata), 64'd0);
    rd(20, 32'h0, "unmapped_rd");
    wr(14, 32'h1234_5678, 4'h1);
    rd(14, 32'h78, "period_strb");

    // One-shot on ch1
    wr(17, 32'h2);
    wr(4, 32'd100); wr(5, 32'd0); wr(6, 32'd0); wr(7, 32'd1);
    timer_value = 64'd99;
    idle(8);
    rd(16, 32'h0, "os_early_pend");
    check("os_early_irq", 64'(irq), 64'd0);
    @(negedge clk);
    timer_value = 64'd100;
    lat = 0;
    while (irq !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("os_irq_latency", 64'(irq === 1'b1 && lat <= 5), 64'd1);
    rd(16, 32'h2, "os_pend");
    rd(7, 32'h0, "os_en_cleared");
    wr(16, 32'h2);
    idle(8);
    rd(16, 32'h0, "os_no_rehit");
    check("os_irq_clr", 64'(irq), 64'd0);

    // Periodic on ch0
    timer_value = 64'd0;
    wr(0, 32'd10); wr(1, 32'd0); wr(2, 32'd20); wr(3, 32'd1);
    for (int k = 0; k < 3; k++) begin
      timer_value = 64'(10 + 20 * k);
      idle(6);
      rd(0, 32'(30 + 20 * k), "per_cmp_lo");
      rd(16, 32'h1, "per_pend");
      wr(16, 32'h1);
      rd(16, 32'h0, "per_pend_clr");
    end

    // Catch-up: CMP 10, PERIOD 20, timer 100 -> five hits, CMP 110
    wr(3, 32'd0);
    wr(0, 32'd10);
    timer_value = 64'd100;
    wr(3, 32'd1);
    idle(30);
    rd(0, 32'd110, "catchup_cmp_lo");
    rd(1, 32'd0, "catchup_cmp_hi");
    rd(16, 32'h1, "catchup_pend");
    wr(3, 32'd0);
    wr(16, 32'h1);

    // 64-bit wrap on ch2; hold timer for exactly one scan round
    timer_value = 64'd0;
    wr(8, 32'hFFFF_FFF0); wr(9, 32'hFFFF_FFFF); wr(10, 32'h20); wr(11, 32'd1);
    @(negedge clk);
    timer_value = 64'hFFFF_FFFF_FFFF_FFF5;
    idle(N_CH);
    timer_value = 64'd0;
    rd(8, 32'h10, "wrap_cmp_lo");
    rd(9, 32'h0, "wrap_cmp_hi");
    rd(16, 32'h4, "wrap_pend");
    wr(11, 32'd0);
    wr(16, 32'h4);

    // Collision: W1C vs hit on ch0 -> set wins
    wr(0, 32'd200); wr(1, 32'd0); wr(2, 32'd1000); wr(3, 32'd1);
    timer_value = 64'd200;
    idle(6);
    rd(16, 32'h1, "coll_pre_pend");
    align_ch0();
    timer_value = 64'd1200;
    valid = 1'b1; address = ADDR_W'(16); wdata = 32'h1; wstrb = 4'hF;
    @(negedge clk);
    valid = 1'b0; wstrb = 4'h0; timer_value = 64'd0;
    check("coll_w1c_ready", 64'(ready), 64'd1);
    rd(16, 32'h1, "coll_set_wins");
    rd(0, 32'd2200, "coll_reload");

    // Collision: CTRL write vs hit on ch0 -> hit discarded
    wr(16, 32'h1);
    rd(16, 32'h0, "coll2_pre_pend");
    align_ch0();
    timer_value = 64'd2200;
    valid = 1'b1; address = ADDR_W'(3); wdata = 32'h1; wstrb = 4'hF;
    @(negedge clk);
    valid = 1'b0; wstrb = 4'h0; timer_value = 64'd0;
    rd(16, 32'h0, "coll_ctrl_wins");
    rd(0, 32'd2200, "coll_cmp_kept");

    // All channels pending, then asynchronous reset
    wr(17, 32'hF);
    for (int c = 0; c < 4; c++) begin
      wr(4 * c, 32'd5); wr(4 * c + 1, 32'd0); wr(4 * c + 2, 32'd0); wr(4 * c + 3, 32'd1);
    end
    timer_value = 64'd5;
    idle(6);
    rd(16, 32'hF, "all_pend");
    check("all_irq", 64'(irq), 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_irq", 64'(irq), 64'd0);
    check("async_rst_ready", 64'(ready), 64'd0);
    check("async_rst_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(16, 32'h0, "post_rst_pend");
    rd(3, 32'h0, "post_rst_en0");
    rd(17, 32'h0, "post_rst_mask");
    rd(4, 32'h0, "post_rst_cmp1");
    check("post_rst_irq", 64'(irq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_timer_alarm_sched.md
IOB_TIMER_ALARM_SCHED -- requirements
Module: iob_timer_alarm_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of alarm channels (1..4).
REQ-002 SHALL have parameter DATA_W, default 32, meaning CPU data width.
REQ-003 SHALL have parameter ADDR_W, default 5, meaning CPU word-address width.
REQ-004 SHALL have port clk  input  1  meaning sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port valid  input  1  meaning CPU request strobe.
REQ-007 SHALL have port address  input  ADDR_W  meaning CPU word address.
REQ-008 SHALL have port wdata  input  DATA_W  meaning CPU write data.
REQ-009 SHALL have port wstrb  input  DATA_W/8  meaning byte write enables; all-zero means read.
REQ-010 SHALL have port rdata  output  DATA_W  meaning CPU read data.
REQ-011 SHALL have port ready  output  1  meaning CPU request completion.
REQ-012 SHALL have port timer_value  input  64  meaning free-running count from the timer core.
REQ-013 SHALL have port irq  output  1  meaning level interrupt, OR of masked pending bits.

Function
REQ-014 SHALL map per-channel registers at word 4*c+k: k=0 CMP_LO, k=1 CMP_HI, k=2 PERIOD (32-bit, 0 = one-shot), k=3 CTRL (bit0 EN, other bits read 0).
REQ-015 SHALL map word 16 PEND (bits[N_CH-1:0], read; write-1-to-clear) and word 17 MASK (bits[N_CH-1:0], read/write); unmapped and c>=N_CH addresses read 0, writes ignored.
REQ-016 SHALL honour wstrb per byte lane on all writable registers; PEND clear uses only lane-enabled bits.
REQ-017 SHALL assert ready exactly one cycle after any cycle with valid=1, for one cycle per request, reads and writes alike.
REQ-018 SHALL present registered rdata in the ready cycle, value sampled at the valid cycle; rdata SHALL be 0 when ready=0.
REQ-019 SHALL share a single 64-bit unsigned >= comparator among channels via scan pointer ptr, which advances 0,1,..,N_CH-1,0 every cycle.
REQ-020 SHALL declare a hit on channel ptr when EN[ptr]=1 and timer_value >= {CMP_HI,CMP_LO}[ptr].
REQ-021 On hit SHALL set PEND[ptr] next cycle and, if PERIOD[ptr]!=0, load CMP[ptr] <= CMP[ptr]+PERIOD (64-bit, modulo 2^64), else clear EN[ptr].
REQ-022 SHALL detect a hit at most N_CH cycles after the condition becomes true (worst-case latency N_CH+1 cycles to PEND).
REQ-023 When a CPU write to CMP_LO/CMP_HI/CTRL of channel c coincides with a hit on c, CPU write SHALL win and the hit SHALL be discarded (PEND unchanged).
REQ-024 When a PEND W1C and a hit set the same bit in one cycle, the set SHALL win.
REQ-025 irq SHALL be registered: irq <= |(PEND & MASK) next state, i.e. rises the cycle PEND bit rises if masked in.
REQ-026 A periodic channel whose updated CMP remains <= timer_value SHALL hit again on its next scan slot (catch-up, one PERIOD per slot).

Reset
REQ-027 On rst_n=0, SHALL immediately clear CMP, PERIOD, CTRL, PEND, MASK, ptr, irq, ready and rdata to 0, regardless of clock.
REQ-028 After rst_n deasserts, scanning SHALL start at ptr=0 on the first clock edge; no channel hits since all EN=0.

Verification
REQ-029 One-shot: ch1 CMP=0x0000_0000_0000_0064, PERIOD=0, MASK=0x2, EN=1, timer ramps from 0 -> PEND=0x2 and irq=1 within 5 cycles of timer=100, EN[1] reads 0, no further hit.
REQ-030 Periodic: ch0 CMP=10, PERIOD=20, EN=1 -> CMP_LO reads 30, 50, 70 after successive hits; PEND[0] re-sets after each W1C.
REQ-031 Wrap: ch2 CMP=0xFFFF_FFFF_FFFF_FFF0, PERIOD=0x20, timer=0xFFFF_FFFF_FFFF_FFF5 -> CMP becomes 0x0000_0000_0000_0010, PEND[2]=1.
REQ-032 Collision: write W1C PEND bit0 in the same cycle as ch0 hit -> PEND[0]=1 afterward; write CTRL ch0 in hit cycle -> PEND[0] stays 0.
REQ-033 Bus: read word 17 after MASK write 0xF -> ready one cycle after valid, rdata=0xF; read word 20 -> rdata=0; wstrb=0x1 write to PERIOD 0x12345678 from 0 -> reads 0x00000078.
REQ-034 Reset mid-operation: drop rst_n while PEND=0xF, irq=1 -> irq, PEND, EN all 0 without a clock edge.
